// File: rtl/cpu_branch_resolver_pkg.sv
// Shared CPU constants and helpers for the branch resolution queue.
package cpu_branch_resolver_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    OUT_NONE,
    OUT_HIT,
    OUT_MISS,
    OUT_EMPTY
  } outcome_e;

  // A not-taken prediction carries no meaningful target, so targets only matter when both are taken.
  function automatic logic is_mispredict(input logic pred_taken, input logic act_taken,
                                         input logic target_match);
    return (pred_taken != act_taken) || (pred_taken && act_taken && !target_match);
  endfunction

endpackage

// File: rtl/cpu_branch_fifo.sv
// Parameterised pointer FIFO: synchronous clear, push/pop, head read and occupancy count.
module cpu_branch_fifo #(
  parameter int WIDTH     = 65,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic [PTR_WIDTH:0]   count
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cpu_branch_resolver.sv
// In-order branch resolution queue: compares execute outcomes with predictions, trains and redirects.
module cpu_branch_resolver
  import cpu_branch_resolver_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [XLEN-1:0]      pred_addr,
  input  logic                 pred_taken,
  input  logic [XLEN-1:0]      pred_target,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic [XLEN-1:0]      resolve_target,
  input  logic                 flush,
  output logic                 update,
  output logic [XLEN-1:0]      update_addr,
  output logic                 update_taken,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [PTR_WIDTH:0]   count,
  output logic [15:0]          mispredicts,
  output logic                 err
);

  localparam int REC_W = 2 * XLEN + 1;
  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);

  logic [REC_W-1:0] head_rec;
  logic [XLEN-1:0]  head_addr;
  logic [XLEN-1:0]  head_target;
  logic             head_taken;
  outcome_e         outcome;
  logic             push_ok;
  logic             fifo_clear;

  assign {head_addr, head_taken, head_target} = head_rec;
  assign pred_ready = (count != FULL);
  assign push_ok    = pred_valid && pred_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    outcome = OUT_NONE;
    if (resolve_valid) begin
      if (count == '0)
        outcome = OUT_EMPTY;
      else if (!flush)
        outcome = is_mispredict(head_taken, resolve_taken, head_target == resolve_target)
                  ? OUT_MISS : OUT_HIT;
    end
  end

  // A mispredict squashes every younger record, including a same-cycle wrong-path push.
  assign fifo_clear = flush || (outcome == OUT_MISS);

  cpu_branch_fifo #(
    .WIDTH     (REC_W),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (push_ok),
    .pop   (outcome == OUT_HIT),
    .wdata ({pred_addr, pred_taken, pred_target}),
    .rdata (head_rec),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update       <= 1'b0;
      update_addr  <= '0;
      update_taken <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      mispredicts  <= '0;
      err          <= 1'b0;
    end else begin
      update   <= (outcome == OUT_HIT) || (outcome == OUT_MISS);
      redirect <= (outcome == OUT_MISS);
      if ((outcome == OUT_HIT) || (outcome == OUT_MISS)) begin
        update_addr  <= head_addr;
        update_taken <= resolve_taken;
      end
      if (outcome == OUT_MISS) begin
        redirect_pc <= resolve_taken ? resolve_target : head_addr + XLEN'(INSTR_BYTES);
        if (mispredicts != 16'hFFFF) mispredicts <= mispredicts + 16'd1;
      end
      if (outcome == OUT_EMPTY) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_branch_resolver.sv
// Bench for cpu_branch_resolver: directed scenarios plus random traffic against a queue model.
module tb_cpu_branch_resolver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_ready, pred_taken;
  logic [31:0] pred_addr, pred_target;
  logic        resolve_valid, resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic        update, update_taken, redirect, err;
  logic [31:0] update_addr, redirect_pc;
  logic [2:0]  count;
  logic [15:0] mispredicts;

  cpu_branch_resolver #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_addr(pred_addr),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .flush(flush),
    .update(update), .update_addr(update_addr), .update_taken(update_taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count), .mispredicts(mispredicts), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  rec_t        q[$];
  bit          e_update, e_utaken, e_redirect, e_err;
  logic [31:0] e_uaddr, e_rpc;
  int          e_mis;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_update = 0; e_utaken = 0; e_redirect = 0; e_err = 0;
    e_uaddr = 0; e_rpc = 0; e_mis = 0;
  endtask

  // Applies the queue rules to the inputs seen at this rising edge.
  task automatic model_edge();
    bit   do_push;
    bit   miss;
    rec_t h;
    do_push    = pred_valid && (q.size() != DEPTH);
    e_update   = 0;
    e_redirect = 0;
    if (resolve_valid && q.size() == 0) begin
      e_err = 1;
      if (!flush && do_push) q.push_back('{pred_addr, pred_taken, pred_target});
    end else if (flush) begin
      q.delete();
    end else if (resolve_valid) begin
      h    = q[0];
      miss = (h.taken != resolve_taken) || (h.taken && h.target != resolve_target);
      e_update = 1;
      e_uaddr  = h.addr;
      e_utaken = resolve_taken;
      if (miss) begin
        e_redirect = 1;
        e_rpc = resolve_taken ? resolve_target : h.addr + 32'd4;
        q.delete();
        if (e_mis < 65535) e_mis++;
      end else begin
        void'(q.pop_front());
        if (do_push) q.push_back('{pred_addr, pred_taken, pred_target});
      end
    end else if (do_push) begin
      q.push_back('{pred_addr, pred_taken, pred_target});
    end
  endtask

  task automatic compare();
    check("count", count, q.size());
    check("pred_ready", pred_ready, q.size() != DEPTH);
    check("update", update, e_update);
    check("redirect", redirect, e_redirect);
    check("err", err, e_err);
    check("mispredicts", mispredicts, e_mis);
    if (e_update) begin
      check("update_addr", update_addr, e_uaddr);
      check("update_taken", update_taken, e_utaken);
    end
    if (e_redirect) check("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic pv, input logic [31:0] pa, input logic pt,
                       input logic [31:0] ptg, input logic rv, input logic rt,
                       input logic [31:0] rtg, input logic fl);
    pred_valid = pv; pred_addr = pa; pred_taken = pt; pred_target = ptg;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg; flush = fl;
    step();
  endtask

  task automatic push(input logic [31:0] pa, input logic pt, input logic [31:0] ptg);
    drive(1'b1, pa, pt, ptg, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_update"}, update, 1'b0);
    check({tag, "_update_addr"}, update_addr, 32'h0);
    check({tag, "_update_taken"}, update_taken, 1'b0);
    check({tag, "_redirect"}, redirect, 1'b0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    check({tag, "_count"}, count, 3'd0);
    check({tag, "_pred_ready"}, pred_ready, 1'b1);
    check({tag, "_mispredicts"}, mispredicts, 16'h0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    rec_t h;
    bit   pv, pt, rv, rt, fl;
    logic [31:0] pa, ptg, rtg;

    rst = 1'b1;
    pred_valid = 0; pred_addr = 0; pred_taken = 0; pred_target = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Correct prediction
    push(32'h100, 1'b1, 32'h200);
    check("t1_count_after_push", count, 3'd1);
    resolve(1'b1, 32'h200);
    check("t1_update", update, 1'b1);
    check("t1_update_addr", update_addr, 32'h100);
    check("t1_update_taken", update_taken, 1'b1);
    check("t1_redirect", redirect, 1'b0);
    check("t1_count", count, 3'd0);

    // Direction mispredict flushes younger entries
    push(32'h40, 1'b1, 32'h80);
    push(32'h44, 1'b0, 32'h0);
    push(32'h48, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    check("t2_redirect", redirect, 1'b1);
    check("t2_redirect_pc", redirect_pc, 32'h44);
    check("t2_count", count, 3'd0);
    check("t2_mispredicts", mispredicts, 16'd1);

    // Target mispredict drops the same-cycle push
    push(32'h10, 1'b1, 32'h20);
    drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 1'b0);
    check("t3_redirect_pc", redirect_pc, 32'h30);
    check("t3_count", count, 3'd0);

    // Fill, reject when full, partial drain, refill, full drain
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    check("t4_ready_full", pred_ready, 1'b0);
    push(32'h1FFF_F000, 1'b0, 32'h0);
    check("t4_count_full", count, 3'd4);
    resolve(1'b0, 32'h0);
    check("t4_addr0", update_addr, 32'h1000);
    resolve(1'b0, 32'h0);
    check("t4_addr1", update_addr, 32'h1004);
    push(32'h1010, 1'b0, 32'h0);
    push(32'h1014, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, 32'h0);
      check("t4_drain_addr", update_addr, 32'h1008 + 32'(4 * i));
      check("t4_drain_redirect", redirect, 1'b0);
    end
    check("t4_count_empty", count, 3'd0);

    // Fall-through wraps at the top of the address space
    push(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    check("t5_no_redirect", redirect, 1'b0);
    push(32'hFFFF_FFFC, 1'b1, 32'h500);
    resolve(1'b0, 32'h0);
    check("t5_redirect", redirect, 1'b1);
    check("t5_redirect_pc", redirect_pc, 32'h0);
    check("t5_mispredicts", mispredicts, 16'd3);

    // Flush with a resolve, then resolve on empty
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(4 * i), 1'b1, 32'h3000);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b1);
    check("t6_flush_count", count, 3'd0);
    check("t6_flush_update", update, 1'b0);
    check("t6_err_before", err, 1'b0);
    resolve(1'b1, 32'h3000);
    check("t6_err", err, 1'b1);
    check("t6_empty_update", update, 1'b0);
    check("t6_empty_redirect", redirect, 1'b0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      pv  = ($urandom_range(0, 99) < 60);
      pa  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pt  = $urandom_range(0, 1);
      ptg = 32'h400 + 32'(4 * $urandom_range(0, 3));
      rv  = (q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 3);
      if (fl && q.size() == 0) rv = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < 70) begin
        h   = q[0];
        rt  = h.taken;
        rtg = h.target;
      end else begin
        rt  = $urandom_range(0, 1);
        rtg = 32'h400 + 32'(4 * $urandom_range(0, 3));
      end
      drive(pv, pa, pt, ptg, rv, rt, rtg, fl);
    end

    // Async reset between edges kills queued entries and a pending redirect
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h700, 1'b1, 32'h800);
    push(32'h704, 1'b0, 32'h0);
    pred_valid = 0; resolve_valid = 1; resolve_taken = 0; resolve_target = 0; flush = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    resolve_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    push(32'h900, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    check("post_rst_update_addr", update_addr, 32'h900);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
